// File: rtl/muldiv_pkg.sv
// Shared codes for the multiply/divide unit: operation and state enums,
// multiplier depth limit, and the decode mapping from function codes.
package muldiv_pkg;

   typedef enum logic [2:0] {
      MD_MULT  = 3'd0,
      MD_MULTU = 3'd1,
      MD_DIV   = 3'd2,
      MD_DIVU  = 3'd3,
      MD_MTHI  = 3'd4,
      MD_MTLO  = 3'd5
   } muldiv_op_t;

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_MUL       = 3'd1,
      S_DIV_SETUP = 3'd2,
      S_DIV_ITER  = 3'd3,
      S_DIV_FIX   = 3'd4
   } md_state_t;

   localparam int MUL_STAGES_MAX = 4;
   localparam int MUL_CNT_W      = $clog2(MUL_STAGES_MAX);

   localparam logic [5:0] FUNC_MTHI  = 6'h11;
   localparam logic [5:0] FUNC_MTLO  = 6'h13;
   localparam logic [5:0] FUNC_MULT  = 6'h18;
   localparam logic [5:0] FUNC_MULTU = 6'h19;
   localparam logic [5:0] FUNC_DIV   = 6'h1A;
   localparam logic [5:0] FUNC_DIVU  = 6'h1B;

   // Decode only calls this for funct codes it has already classified as mult/div.
   function automatic muldiv_op_t func_to_op(input logic [5:0] func);
      muldiv_op_t op;
      case (func)
         FUNC_MULTU: op = MD_MULTU;
         FUNC_DIV:   op = MD_DIV;
         FUNC_DIVU:  op = MD_DIVU;
         FUNC_MTHI:  op = MD_MTHI;
         FUNC_MTLO:  op = MD_MTLO;
         default:    op = MD_MULT;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/muldiv_if.sv
// Issue/result bundle between decode/execute and the multiply/divide unit.
interface muldiv_if import muldiv_pkg::*; #(parameter int WIDTH = 32) ();
   logic             start_i;
   muldiv_op_t       op_i;
   logic [WIDTH-1:0] rs_i;
   logic [WIDTH-1:0] rt_i;
   logic             flush_i;
   logic             busy_o;
   logic             done_o;
   logic [WIDTH-1:0] hi_o;
   logic [WIDTH-1:0] lo_o;

   modport master (
      output start_i, op_i, rs_i, rt_i, flush_i,
      input  busy_o, done_o, hi_o, lo_o
   );

   modport slave (
      input  start_i, op_i, rs_i, rt_i, flush_i,
      output busy_o, done_o, hi_o, lo_o
   );
endinterface

// File: rtl/muldiv_divider.sv
// Iterative restoring divider on unsigned magnitudes: one quotient bit per
// cycle for WIDTH cycles after a start pulse.
module muldiv_divider #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_start,
   input  logic             i_abort,
   input  logic [WIDTH-1:0] i_dividend,
   input  logic [WIDTH-1:0] i_divisor,
   output logic             o_done,
   output logic [WIDTH-1:0] o_quot,
   output logic [WIDTH-1:0] o_rem
);
   localparam int CNT_W = $clog2(WIDTH);

   logic             r_busy;
   logic [CNT_W-1:0] r_cnt;
   logic [WIDTH-1:0] r_quot;
   logic [WIDTH-1:0] r_rem;
   logic [WIDTH-1:0] r_dvs;

   logic [WIDTH:0]   w_shift;
   logic             w_ge;
   logic [WIDTH-1:0] w_sub;

   // Partial remainder stays below the divisor, so the difference fits WIDTH bits.
   assign w_shift = {r_rem, r_quot[WIDTH-1]};
   assign w_ge    = (w_shift >= {1'b0, r_dvs});
   assign w_sub   = w_shift[WIDTH-1:0] - r_dvs;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_busy <= 1'b0;
         r_cnt  <= '0;
         r_quot <= '0;
         r_rem  <= '0;
         r_dvs  <= '0;
      end else if (i_abort) begin
         r_busy <= 1'b0;
      end else if (i_start) begin
         r_busy <= 1'b1;
         r_cnt  <= CNT_W'(WIDTH - 1);
         r_quot <= i_dividend;
         r_rem  <= '0;
         r_dvs  <= i_divisor;
      end else if (r_busy) begin
         r_rem  <= w_ge ? w_sub : w_shift[WIDTH-1:0];
         r_quot <= {r_quot[WIDTH-2:0], w_ge};
         r_cnt  <= r_cnt - 1'b1;
         if (r_cnt == '0) r_busy <= 1'b0;
      end
   end

   // High during the cycle whose closing edge produces the last quotient bit.
   assign o_done = r_busy && (r_cnt == '0);
   assign o_quot = r_quot;
   assign o_rem  = r_rem;
endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit owning the architectural HI/LO registers:
// pipelined multiplier, iterative divider, MTHI/MTLO writes, flush.
module muldiv_unit import muldiv_pkg::*; #(
   parameter int WIDTH         = 32,
   parameter int MUL_STAGES    = 2,
   parameter int DIV_ZERO_FAST = 0
) (
   input logic      clk,
   input logic      rst_n,
   muldiv_if.slave  bus
);
   localparam logic [MUL_CNT_W-1:0] MUL_LAST = MUL_CNT_W'(MUL_STAGES - 1);

   md_state_t            r_state, w_state_next;
   muldiv_op_t           r_op;
   logic [WIDTH-1:0]     r_a, r_b, r_hi, r_lo;
   logic                 r_dz, r_qneg, r_rneg, r_done;
   logic [MUL_CNT_W-1:0] r_mul_cnt;
   logic [2*WIDTH-1:0]   r_prod [MUL_STAGES];

   logic                 w_accept, w_wr_hilo, w_div_start, w_div_last, w_mul_signed;
   logic [2*WIDTH-1:0]   w_mul_a, w_mul_b, w_prod;
   logic [WIDTH-1:0]     w_mag_a, w_mag_b, w_quot, w_rem, w_res_hi, w_res_lo;

   assign w_accept = (r_state == S_IDLE) && bus.start_i && !bus.flush_i;

   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      w_wr_hilo    = 1'b0;
      w_div_start  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               case (bus.op_i)
                  MD_MULT, MD_MULTU: w_state_next = S_MUL;
                  MD_DIV, MD_DIVU:
                     w_state_next = (DIV_ZERO_FAST != 0 && bus.rt_i == '0) ? S_DIV_FIX : S_DIV_SETUP;
                  default: w_state_next = S_IDLE;
               endcase
            end
         end
         S_MUL: begin
            if (r_mul_cnt == MUL_LAST) begin
               w_wr_hilo    = 1'b1;
               w_state_next = S_IDLE;
            end
         end
         S_DIV_SETUP: begin
            w_div_start  = 1'b1;
            w_state_next = S_DIV_ITER;
         end
         S_DIV_ITER: if (w_div_last) w_state_next = S_DIV_FIX;
         S_DIV_FIX: begin
            w_wr_hilo    = 1'b1;
            w_state_next = S_IDLE;
         end
         default: w_state_next = S_IDLE;
      endcase
      if (bus.flush_i && r_state != S_IDLE) begin
         w_state_next = S_IDLE;
         w_wr_hilo    = 1'b0;
         w_div_start  = 1'b0;
      end
   end

   // Sign/zero-extending to the full product width keeps the wrap-around product exact.
   assign w_mul_signed = (bus.op_i == MD_MULT);
   assign w_mul_a = {{WIDTH{w_mul_signed & bus.rs_i[WIDTH-1]}}, bus.rs_i};
   assign w_mul_b = {{WIDTH{w_mul_signed & bus.rt_i[WIDTH-1]}}, bus.rt_i};
   assign w_prod  = w_mul_a * w_mul_b;

   for (genvar gi = 0; gi < MUL_STAGES; gi++) begin : g_mul_pipe
      if (gi == 0) begin : g_load
         always_ff @(posedge clk) if (w_accept) r_prod[0] <= w_prod;
      end else begin : g_shift
         always_ff @(posedge clk) r_prod[gi] <= r_prod[gi-1];
      end
   end

   assign w_mag_a = (r_op == MD_DIV && r_a[WIDTH-1]) ? -r_a : r_a;
   assign w_mag_b = (r_op == MD_DIV && r_b[WIDTH-1]) ? -r_b : r_b;

   muldiv_divider #(.WIDTH(WIDTH)) u_divider (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_start    (w_div_start),
      .i_abort    (bus.flush_i),
      .i_dividend (w_mag_a),
      .i_divisor  (w_mag_b),
      .o_done     (w_div_last),
      .o_quot     (w_quot),
      .o_rem      (w_rem)
   );

   always_comb begin
      w_res_hi = '0;
      w_res_lo = '0;
      if (r_state == S_MUL) begin
         {w_res_hi, w_res_lo} = r_prod[MUL_STAGES-1];
      end else if (!r_dz) begin
         w_res_lo = r_qneg ? -w_quot : w_quot;
         w_res_hi = r_rneg ? -w_rem  : w_rem;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_hi      <= '0;
         r_lo      <= '0;
         r_done    <= 1'b0;
         r_op      <= MD_MULT;
         r_a       <= '0;
         r_b       <= '0;
         r_dz      <= 1'b0;
         r_qneg    <= 1'b0;
         r_rneg    <= 1'b0;
         r_mul_cnt <= '0;
      end else begin
         r_done <= w_wr_hilo;
         if (w_wr_hilo) begin
            r_hi <= w_res_hi;
            r_lo <= w_res_lo;
         end else if (w_accept && bus.op_i == MD_MTHI) begin
            r_hi <= bus.rs_i;
         end else if (w_accept && bus.op_i == MD_MTLO) begin
            r_lo <= bus.rs_i;
         end
         if (w_accept) begin
            r_op      <= bus.op_i;
            r_a       <= bus.rs_i;
            r_b       <= bus.rt_i;
            r_dz      <= (bus.rt_i == '0);
            r_mul_cnt <= '0;
         end else if (r_state == S_MUL) begin
            r_mul_cnt <= r_mul_cnt + 1'b1;
         end
         if (r_state == S_DIV_SETUP) begin
            r_qneg <= (r_op == MD_DIV) && (r_a[WIDTH-1] ^ r_b[WIDTH-1]);
            r_rneg <= (r_op == MD_DIV) && r_a[WIDTH-1];
         end
      end
   end

   assign bus.busy_o = (r_state != S_IDLE);
   assign bus.done_o = r_done;
   assign bus.hi_o   = r_hi;
   assign bus.lo_o   = r_lo;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: a default instance plus a fast variant
// (MUL_STAGES=1, DIV_ZERO_FAST=1), checked against hand-computed results.
module tb_muldiv_unit;
   import muldiv_pkg::*;

   localparam int W = 32;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   muldiv_if #(.WIDTH(W)) bus   ();
   muldiv_if #(.WIDTH(W)) bus_f ();

   muldiv_unit #(.WIDTH(W), .MUL_STAGES(2), .DIV_ZERO_FAST(0)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   muldiv_unit #(.WIDTH(W), .MUL_STAGES(1), .DIV_ZERO_FAST(1)) u_fast (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_f)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Presents one issue cycle; returns #1 after the edge that samples it.
   task automatic issue(input bit fast, input muldiv_op_t op, input logic [31:0] a,
                        input logic [31:0] b, input bit fl);
      @(negedge clk);
      if (fast) begin
         bus_f.start_i = 1'b1; bus_f.op_i = op; bus_f.rs_i = a; bus_f.rt_i = b; bus_f.flush_i = fl;
      end else begin
         bus.start_i = 1'b1; bus.op_i = op; bus.rs_i = a; bus.rt_i = b; bus.flush_i = fl;
      end
      @(posedge clk);
      #1;
      bus.start_i = 1'b0; bus.flush_i = 1'b0;
      bus_f.start_i = 1'b0; bus_f.flush_i = 1'b0;
      $display("txn fast=%0d op=%s rs=%h rt=%h flush=%0d", fast, op.name(), a, b, fl);
   endtask

   task automatic wait_done(input bit fast, input string tag, input int exp_lat,
                            input logic [31:0] exp_hi, input logic [31:0] exp_lo);
      int lat = 0;
      bit bad_busy = 1'b0;
      for (int i = 1; i <= 60; i++) begin
         @(posedge clk);
         #1;
         if (fast ? bus_f.done_o : bus.done_o) begin
            lat = i;
            break;
         end
         if (!(fast ? bus_f.busy_o : bus.busy_o)) bad_busy = 1'b1;
      end
      check({tag, " latency"}, 64'(lat), 64'(exp_lat));
      check({tag, " busy_during"}, 64'(bad_busy), 64'd0);
      check({tag, " busy_at_done"}, 64'(fast ? bus_f.busy_o : bus.busy_o), 64'd0);
      check({tag, " hi"}, 64'(fast ? bus_f.hi_o : bus.hi_o), 64'(exp_hi));
      check({tag, " lo"}, 64'(fast ? bus_f.lo_o : bus.lo_o), 64'(exp_lo));
   endtask

   // Runs n cycles and reports whether done_o ever rose.
   task automatic idle_cycles(input int n, output bit saw_done);
      saw_done = 1'b0;
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         if (bus.done_o) saw_done = 1'b1;
      end
   endtask

   initial begin
      bit saw;
      bus.start_i = 0; bus.op_i = MD_MULT; bus.rs_i = '0; bus.rt_i = '0; bus.flush_i = 0;
      bus_f.start_i = 0; bus_f.op_i = MD_MULT; bus_f.rs_i = '0; bus_f.rt_i = '0; bus_f.flush_i = 0;

      repeat (3) @(posedge clk);
      #1;
      check("reset hi", 64'(bus.hi_o), 64'd0);
      check("reset lo", 64'(bus.lo_o), 64'd0);
      check("reset busy", 64'(bus.busy_o), 64'd0);
      check("reset done", 64'(bus.done_o), 64'd0);
      @(negedge clk) rst_n = 1'b1;

      issue(0, MD_MTHI, 32'hDEADBEEF, 32'h0, 0);
      check("mthi hi", 64'(bus.hi_o), 64'hDEADBEEF);
      check("mthi lo", 64'(bus.lo_o), 64'd0);
      check("mthi busy", 64'(bus.busy_o), 64'd0);
      issue(0, MD_MTLO, 32'h12345678, 32'h0, 0);
      check("mtlo lo", 64'(bus.lo_o), 64'h12345678);
      check("mtlo hi", 64'(bus.hi_o), 64'hDEADBEEF);
      check("mtlo busy", 64'(bus.busy_o), 64'd0);
      check("mtlo done", 64'(bus.done_o), 64'd0);

      issue(0, MD_MULT, 32'hFFFFFFFE, 32'd3, 0);
      wait_done(0, "mult -2*3", 2, 32'hFFFFFFFF, 32'hFFFFFFFA);
      issue(0, MD_MULTU, 32'hFFFFFFFE, 32'd3, 0);
      wait_done(0, "multu", 2, 32'h00000002, 32'hFFFFFFFA);

      issue(0, MD_DIV, 32'hFFFFFFF9, 32'd2, 0);
      wait_done(0, "div -7/2", 34, 32'hFFFFFFFF, 32'hFFFFFFFD);
      issue(0, MD_DIVU, 32'd100, 32'd7, 0);
      wait_done(0, "divu 100/7", 34, 32'd2, 32'd14);
      issue(0, MD_DIV, 32'd7, 32'hFFFFFFFE, 0);
      wait_done(0, "div 7/-2", 34, 32'd1, 32'hFFFFFFFD);
      issue(0, MD_DIV, 32'h80000000, 32'hFFFFFFFF, 0);
      wait_done(0, "div min/-1", 34, 32'd0, 32'h80000000);
      issue(0, MD_DIVU, 32'h00001234, 32'd0, 0);
      wait_done(0, "divu by 0", 34, 32'd0, 32'd0);

      // Flush mid-divide: HI/LO must keep the values written just before.
      issue(0, MD_MTHI, 32'hAAAA5555, 32'h0, 0);
      issue(0, MD_MTLO, 32'h5555AAAA, 32'h0, 0);
      issue(0, MD_DIVU, 32'd100, 32'd7, 0);
      repeat (9) @(posedge clk);
      @(negedge clk) bus.flush_i = 1'b1;
      @(posedge clk);
      #1;
      bus.flush_i = 1'b0;
      check("flush busy", 64'(bus.busy_o), 64'd0);
      check("flush done", 64'(bus.done_o), 64'd0);
      idle_cycles(40, saw);
      check("flush no_done", 64'(saw), 64'd0);
      check("flush hi", 64'(bus.hi_o), 64'hAAAA5555);
      check("flush lo", 64'(bus.lo_o), 64'h5555AAAA);

      issue(0, MD_MTHI, 32'h00000099, 32'h0, 1);
      check("flush+start dropped", 64'(bus.hi_o), 64'hAAAA5555);

      // Start while busy is ignored; changed operands must not leak in.
      issue(0, MD_DIVU, 32'd100, 32'd7, 0);
      @(negedge clk);
      bus.start_i = 1'b1; bus.op_i = MD_MULT; bus.rs_i = 32'd3; bus.rt_i = 32'd3;
      @(posedge clk);
      #1;
      bus.start_i = 1'b0;
      wait_done(0, "divu busy-start", 33, 32'd2, 32'd14);
      idle_cycles(4, saw);
      check("busy-start no_extra", 64'(saw), 64'd0);

      // Back-to-back multiplies on the done cycle, then an MTLO.
      issue(0, MD_MULT, 32'd5, 32'd7, 0);
      wait_done(0, "mult 5*7", 2, 32'd0, 32'd35);
      issue(0, MD_MULT, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
      wait_done(0, "mult b2b", 2, 32'd0, 32'd1);
      issue(0, MD_MTLO, 32'hCAFEF00D, 32'h0, 0);
      idle_cycles(4, saw);
      check("b2b mtlo lo", 64'(bus.lo_o), 64'hCAFEF00D);
      check("b2b mtlo hi", 64'(bus.hi_o), 64'd0);
      check("b2b no_stale_done", 64'(saw), 64'd0);

      issue(0, MD_MTHI, 32'h11111111, 32'h0, 0);
      issue(0, MD_DIV, 32'd100, 32'd7, 0);
      repeat (5) @(posedge clk);
      @(negedge clk) rst_n = 1'b0;
      @(posedge clk);
      #1;
      check("midrst hi", 64'(bus.hi_o), 64'd0);
      check("midrst lo", 64'(bus.lo_o), 64'd0);
      check("midrst busy", 64'(bus.busy_o), 64'd0);
      check("midrst done", 64'(bus.done_o), 64'd0);
      @(negedge clk) rst_n = 1'b1;
      idle_cycles(40, saw);
      check("midrst no_done", 64'(saw), 64'd0);

      issue(1, MD_MULT, 32'd3, 32'd5, 0);
      wait_done(1, "fast mult", 1, 32'd0, 32'd15);
      issue(1, MD_DIV, 32'h00001234, 32'd0, 0);
      wait_done(1, "fast div0", 1, 32'd0, 32'd0);
      issue(1, MD_DIV, 32'd100, 32'hFFFFFFF9, 0);
      wait_done(1, "fast div 100/-7", 34, 32'd2, 32'hFFFFFFF2);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Parametrised multi-cycle multiply/divide unit that owns the architectural HI/LO registers.
- Successor to the single-cycle combinational mult/div path.
- Sits beside the ALU in the execute stage. Decode issues one operation with a start pulse; the pipeline stalls on busy_o. MFHI/MFLO read hi_o/lo_o directly.
- New over the previous generation:
  - generic WIDTH
  - configurable multiplier pipeline depth
  - iterative restoring divider
  - busy/done handshake
  - flush/abort
  - defined divide-by-zero and overflow results

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.
- MUL_STAGES, 2, multiplier latency in cycles from start to done (range 1..4).
- DIV_ZERO_FAST, 0, when 1 a divide-by-zero completes in 1 cycle; when 0 it takes the full divide latency.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous reset, active low.
- start_i  in  1  issue strobe; accepted only when busy_o=0.
- op_i  in  3  muldiv_op_t: MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO.
- rs_i  in  WIDTH  operand A (dividend / multiplicand / MTHI-MTLO source).
- rt_i  in  WIDTH  operand B (divisor / multiplier).
- flush_i  in  1  abort any in-flight operation.
- busy_o  out  1  operation in flight.
- done_o  out  1  one-cycle pulse when HI/LO are updated by a MULT/DIV.
- hi_o  out  WIDTH  architectural HI.
- lo_o  out  WIDTH  architectural LO.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - hi_o=0, lo_o=0, busy_o=0, done_o=0, FSM to IDLE.
  - Takes priority over start_i and flush_i; aborts any operation mid-flight.
- FSM states: IDLE, MUL, DIV_SETUP, DIV_ITER, DIV_FIX.
- Issue:
  - start_i in IDLE latches op_i, rs_i, rt_i at that edge.
  - start_i while busy_o=1 is ignored; no queuing.
- MTHI / MTLO:
  - Write HI or LO at the accepting edge; the other register is unchanged.
  - busy_o stays 0; done_o stays 0; state stays IDLE.
- MULT / MULTU:
  - Full 2*WIDTH product, signed or unsigned; {HI,LO} = product.
  - busy_o=1 for MUL_STAGES cycles, then done_o=1 on the same edge that HI/LO update, busy_o=0.
  - Back-to-back: a new start is accepted on the cycle done_o is high (busy_o already 0).
- DIV / DIVU:
  - DIV_SETUP (1 cycle): take magnitudes for DIV; record quotient sign = sign(rs) xor sign(rt) and remainder sign = sign(rs).
  - DIV_ITER: WIDTH cycles of restoring shift-subtract, one quotient bit per cycle; counter counts WIDTH-1 down to 0.
  - DIV_FIX (1 cycle): apply signs; LO=quotient, HI=remainder; done_o pulses.
  - Total latency WIDTH+2 cycles (34 at WIDTH=32).
  - Quotient truncates toward zero; remainder takes the dividend's sign.
- Boundaries:
  - Divisor 0: HI=0, LO=0. Latency 1 cycle if DIV_ZERO_FAST=1, else WIDTH+2.
  - Signed DIV of most-negative by -1: LO=most-negative, HI=0; no exception.
  - Operands are captured at issue; input changes while busy have no effect.
- Flush:
  - flush_i=1 returns to IDLE next edge; HI/LO keep their pre-operation values; no done_o.
  - flush_i together with start_i in IDLE: the start is dropped.
  - flush_i in IDLE with no start: no effect.
- hi_o/lo_o hold their old values throughout an operation (no partial results visible).

Decomposition:
- Shared codes package:
  - muldiv_op_t enum
  - MUL_STAGES_MAX constant
  - mapping from FUNC_MULT/MULTU/DIV/DIVU/MTHI/MTLO to muldiv_op_t, as a function used by decode
- One sub-module, muldiv_divider:
  - holds the iterative restoring core: magnitude in, quotient/remainder out
  - own start/done handshake
- The multiplier is inline: a shift-register pipeline of MUL_STAGES depth on a registered product.

Test Plan:
- Reset then MTHI rs=0xDEADBEEF, then MTLO rs=0x12345678 -> hi_o=0xDEADBEEF, lo_o=0x12345678 on the accepting edges; busy_o never 1.
- MULT rs=0xFFFFFFFE (-2), rt=3, MUL_STAGES=2 -> done_o 2 cycles after start; HI=0xFFFFFFFF, LO=0xFFFFFFFA. MULTU same operands -> HI=0x00000002, LO=0xFFFFFFFA.
- DIV rs=-7 (0xFFFFFFF9), rt=2 -> done_o exactly 34 cycles after start; LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). DIVU rs=100, rt=7 -> LO=14, HI=2.
- DIV rs=0x80000000, rt=0xFFFFFFFF -> LO=0x80000000, HI=0. DIVU rt=0 -> HI=0, LO=0; latency 34, or 1 with DIV_ZERO_FAST=1.
- Start DIV, assert flush_i at cycle 10 -> busy_o low next cycle, no done_o, HI/LO equal their pre-start values. Start pulse during busy_o=1 -> ignored, result unchanged. Assert rst_n=0 mid-DIV -> all outputs 0 next edge.
- Back-to-back MULT on the done_o cycle, then MTLO -> both results correct; the MTLO value is not overwritten by a stale pipeline stage.
